mesh_link_port: RTL
===================

// Module: mesh_link_port
// PURPOSE
//  Tile-side endpoint of a point-to-point mesh link. It is the sequential end of the combinational
//  tile A/B link: it drives send_data/send_ready/recv_ready and consumes send_done/recv_valid.
//  A TX queue and an RX queue register the link side, so no tile-side input reaches a link output
//  combinationally. One instance per tile per link direction pair.
// PARAMETERS
//  WORD_W    32  data width; must equal the width of the shared `word` type
//  TX_DEPTH  4   TX queue entries; power of 2, >= 2
//  RX_DEPTH  4   RX queue entries; power of 2, >= 2
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  reset       in   1       synchronous, active-high
//  tx_data     in   WORD_W  tile word to send
//  tx_valid    in   1       tile offers tx_data
//  tx_ready    out  1       TX queue not full
//  rx_data     out  WORD_W  head of RX queue
//  rx_valid    out  1       RX queue not empty
//  rx_ready    in   1       tile consumes rx_data
//  send_data   out  WORD_W  head of TX queue to link
//  send_ready  out  1       TX queue not empty
//  send_done   in   1       link accepted send_data this cycle
//  recv_data   in   WORD_W  word from link
//  recv_ready  out  1       RX queue not full
//  recv_valid  in   1       link delivers recv_data this cycle
//  link_err    out  1       sticky protocol-violation flag
// BEHAVIOUR
//  - Reset (sync, active-high): pointers and counts go to 0 and link_err goes to 0. First cycle
//    after reset: tx_ready=1, rx_valid=0, send_ready=0, recv_ready=1, link_err=0.
//    Inputs are ignored while reset=1. Queued words are discarded on reset mid-operation.
//  - Every output is a function of registered state only. There is no tile-to-link
//    combinational path.
//  - TX push: tx_valid & tx_ready. TX pop: send_done & send_ready.
//    send_data = TX head; send_ready = (tx_count != 0).
//    Latency: a push into an empty queue gives send_ready=1 on the next cycle.
//  - RX push: recv_valid & recv_ready. RX pop: rx_valid & rx_ready.
//    rx_data = RX head; rx_valid = (rx_count != 0).
//    Latency: a word received into an empty queue is visible on rx_data on the next cycle.
//  - Full: tx_ready = (tx_count != TX_DEPTH) and recv_ready = (rx_count != RX_DEPTH), both from
//    registered count. A pop in the same cycle does NOT allow a push into a full queue.
//  - Simultaneous push and pop on a non-empty, non-full queue: count unchanged, both pointers
//    advance, FIFO order is preserved.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Counts are $clog2(DEPTH)+1 bits.
//  - Protocol errors are each counted as an event:
//    (a) send_done=1 while send_ready=0;
//    (b) recv_valid=1 while recv_ready=0.
//    On either error: link_err is set on the next cycle and held until reset. No pop happens on (a).
//    No push happens on (b): the word is dropped and rx_count is unchanged.
//  - No other state machine exists. Each queue is in one of three states, EMPTY, PARTIAL or FULL,
//    decoded from its count.
// STRUCTURE
//  - Shared `word` typedef stays in the common types header. WORD_W defaults to its width.
//  - One sub-module, link_fifo #(WIDTH, DEPTH), with push/pop/din/dout/count/full/empty outputs.
//    It is instantiated twice, as TX and RX. The top level holds only the handshake glue and
//    link_err.
//  - Estimated size: about 110 lines for link_fifo and about 90 lines for the top level.
// TESTING
//  1. Reset, then push 0xA5A50001 at cycle 0 -> send_ready=1 at cycle 1; send_done at cycle 2
//     -> send_ready=0 at cycle 3.
//  2. Push 0x1..0x5 on consecutive cycles with send_done=0 -> tx_ready=0 after the 4th push; 0x5
//     is never queued; drain order is 0x1,0x2,0x3,0x4.
//  3. rx_ready=0, recv_valid on 4 cycles with 0x10..0x13 -> recv_ready=0 after the 4th; rx_ready=1
//     -> pops 0x10..0x13 in order, then rx_valid=0.
//  4. tx_count=2, then push 0x77 and send_done in the same cycle -> tx_count stays 2; head advances;
//     0x77 exits last.
//  5. RX full, recv_valid=1 with 0xDEAD -> link_err=1 on the next cycle; rx_count=4; 0xDEAD never
//     appears. Separately, send_done with TX empty -> link_err=1.
//  6. 3 words in TX, 2 in RX, reset for 1 cycle -> next cycle send_ready=0, rx_valid=0,
//     tx_ready=1, recv_ready=1, link_err=0.

Source files
------------

// File: rtl/mesh_link_port_pkg.sv
// mesh_link_port_pkg: shared word type and queue-state decode for the mesh link port
package mesh_link_port_pkg;

    typedef logic [31:0] word;

    localparam int WORD_BITS = $bits(word);

    typedef enum logic [1:0] {
        Q_EMPTY,
        Q_PARTIAL,
        Q_FULL
    } qstate_t;

    function automatic qstate_t q_state(input int count, input int depth);
        return (count == 0) ? Q_EMPTY : ((count == depth) ? Q_FULL : Q_PARTIAL);
    endfunction

endpackage

// File: rtl/mesh_link_port_fifo.sv
// link_fifo: circular-buffer queue that registers one side of the mesh link
module link_fifo
    import mesh_link_port_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    qstate_t          w_state;
    logic             w_push;
    logic             w_pop;

    assign w_state = q_state(int'(r_count), DEPTH);
    assign full    = (w_state == Q_FULL);
    assign empty   = (w_state == Q_EMPTY);
    assign w_push  = push & ~full;
    assign w_pop   = pop & ~empty;
    assign dout    = r_mem[r_rd];
    assign count   = r_count;

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // storage needs no reset; the pointers define which entries are live
    always_ff @(posedge clk) begin
        if (w_push && !reset) r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/mesh_link_port.sv
// mesh_link_port: tile-side endpoint of a mesh link with registered TX/RX queues
module mesh_link_port
    import mesh_link_port_pkg::*;
#(
    parameter int WORD_W   = WORD_BITS,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [WORD_W-1:0] send_data,
    output logic              send_ready,
    input  logic              send_done,
    input  logic [WORD_W-1:0] recv_data,
    output logic              recv_ready,
    input  logic              recv_valid,
    output logic              link_err
);

    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;

    logic [TCW-1:0] w_tx_count;
    logic [RCW-1:0] w_rx_count;
    logic           w_tx_full;
    logic           w_tx_empty;
    logic           w_rx_full;
    logic           w_rx_empty;
    logic           w_err;
    logic           r_err;

    link_fifo #(.WIDTH(WORD_W), .DEPTH(TX_DEPTH)) u_tx (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid),
        .pop   (send_done),
        .din   (tx_data),
        .dout  (send_data),
        .count (w_tx_count),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    link_fifo #(.WIDTH(WORD_W), .DEPTH(RX_DEPTH)) u_rx (
        .clk   (clk),
        .reset (reset),
        .push  (recv_valid),
        .pop   (rx_ready),
        .din   (recv_data),
        .dout  (rx_data),
        .count (w_rx_count),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    assign tx_ready   = (w_tx_count != TCW'(TX_DEPTH));
    assign send_ready = (w_tx_count != '0);
    assign recv_ready = (w_rx_count != RCW'(RX_DEPTH));
    assign rx_valid   = (w_rx_count != '0);
    assign w_err      = (send_done & w_tx_empty) | (recv_valid & w_rx_full);
    assign link_err   = r_err;

    // sticky flag for link-side handshake violations
    always_ff @(posedge clk) begin
        if (reset) r_err <= 1'b0;
        else if (w_err) r_err <= 1'b1;
    end

endmodule
